// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
// Multiply is radix-2 shift-add and divide is radix-2 restoring division.
// Both work on operand magnitudes, and the sign is fixed up when the state
// machine enters DONE. Divide-by-zero and signed overflow bypass CALC.
// Handshake: start is sampled only in IDLE. stall_req holds the upstream
// segment registers until the DONE cycle. done is a one-cycle pulse, and
// result holds its value until the next DONE entry.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] acc_q, acc_d;    // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd_q, opnd_d;  // multiplicand magnitude or divisor magnitude
  logic        neg_q, neg_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;

  // Operand decode at the IDLE capture point
  logic        a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf, sign_in;
  logic [31:0] a_mag, b_mag;

  // One iteration of the datapath and the sign-corrected final value
  logic [32:0] mul_sum, div_upper, div_diff;
  logic [63:0] mul_next, div_next, step_next, prod_fix;
  logic [31:0] field, field_fix, final_val;

  // Decode signedness, magnitudes, result sign and fast-path conditions
  always_comb begin
    a_signed = (op == 3'b000) | (op == 3'b001) | (op == 3'b010) |
               (op == 3'b100) | (op == 3'b110);
    b_signed = (op == 3'b000) | (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    a_neg    = a_signed & a[31];
    b_neg    = b_signed & b[31];
    a_mag    = a_neg ? (32'd0 - a) : a;
    b_mag    = b_neg ? (32'd0 - b) : b;
    div_zero = op[2] & (b == 32'd0);
    div_ovf  = op[2] & ~op[0] & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
    // Remainder follows the dividend; everything else is sign(a) ^ sign(b)
    sign_in  = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
  end

  // One shift-add or restoring-divide step, plus sign correction of its output
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opnd_q : 32'd0)};
    mul_next  = {mul_sum, acc_q[31:1]};
    div_upper = acc_q[63:31];
    div_diff  = div_upper - {1'b0, opnd_q};
    div_next  = div_diff[32] ? {acc_q[62:0], 1'b0}
                             : {div_diff[31:0], acc_q[30:0], 1'b1};
    step_next = op_q[2] ? div_next : mul_next;
    prod_fix  = neg_q ? (64'd0 - step_next) : step_next;
    field     = op_q[1] ? step_next[63:32] : step_next[31:0];
    field_fix = neg_q ? (32'd0 - field) : field;
    if (op_q[2])               final_val = field_fix;
    else if (op_q[1:0] == 2'b00) final_val = prod_fix[31:0];
    else                       final_val = prod_fix[63:32];
  end

  // Next-state logic: IDLE capture, CALC iteration, DONE pulse, flush override
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          neg_d = sign_in;
          cnt_d = 6'd0;
          if (div_zero) begin
            result_d = op[1] ? a : 32'hFFFF_FFFF;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else if (div_ovf) begin
            result_d = op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = S_DONE;
            done_d   = 1'b1;
          end else begin
            acc_d   = op[2] ? {32'd0, a_mag} : {32'd0, b_mag};
            opnd_d  = op[2] ? b_mag : a_mag;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          result_d = final_val;
          state_d  = S_DONE;
          done_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = 6'd0;
      result_d = result_q;
      done_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      op_q     <= 3'd0;
      acc_q    <= 64'd0;
      opnd_q   <= 32'd0;
      neg_q    <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q == S_CALC);
  assign stall_req = ~rst & (((state_q == S_IDLE) & start & ~flush) | busy);
  assign done      = done_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        stall_req, busy, done;
  logic [31:0] result;

  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  mul_div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model of RV32M semantics
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] ex, ey, p;
    int sx, sy;
    ex = (o == 3'b011) ? {32'd0, x} : {{32{x[31]}}, x};
    ey = (o == 3'b010 || o == 3'b011) ? {32'd0, y} : {{32{y[31]}}, y};
    p  = ex * ey;
    sx = x;
    sy = y;
    case (o)
      3'b000: return p[31:0];
      3'b001, 3'b010, 3'b011: return p[63:32];
      default: begin
        if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
        if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
          return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
          3'b100:  return sx / sy;
          3'b101:  return x / y;
          3'b110:  return sx % sy;
          default: return x % y;
        endcase
      end
    endcase
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) check("spurious_done", 32'd1, 32'd0);
      else check("result", result, exp_q.pop_front());
    end
  end

  // Issue one operation, then check latency and stall duration
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int lat);
    int n, st;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(exp);
    #1;
    check("stall_on_start", {31'd0, stall_req}, 32'd1);
    st = 1;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done && stall_req) st++;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      op = 3'($urandom_range(0, 7));
    end while (!done && n < 100);
    check("latency", n, lat);
    check("stall_cycles", st, lat);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    int          rl;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall_req}, 32'd0);
    check("rst_result", result, 32'd0);
    rst = 1'b0;

    // Directed cases
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_op(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 33);
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 33);
    do_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_op(3'b110, 32'd5, 32'd0, 32'd5, 1);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Randomised cases against the model
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0: ry = 32'd0;
        1: ry = 32'hFFFF_FFFF;
        2: ry = 32'($urandom_range(1, 20));
        default: ry = $urandom;
      endcase
      rl = (ro[2] && (ry == 32'd0 || (!ro[0] && rx == 32'h8000_0000 && ry == 32'hFFFF_FFFF))) ? 1 : 33;
      do_op(ro, rx, ry, model(ro, rx, ry), rl);
    end

    // start pulsed during CALC is ignored: exactly one done for MUL 3*5
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
    exp_q.push_back(32'd15);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'd100; b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    repeat (40) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    // flush mid-CALC: back to IDLE, no done, result keeps 15
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, 32'd15);
    repeat (40) @(negedge clk);
    check("flush_hold", result, 32'd15);

    // Asynchronous reset mid-CALC, then a fresh MUL 3*4
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_stall", {31'd0, stall_req}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b000, 32'd3, 32'd4, 32'd12, 33);
    repeat (3) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 One clock; reset is asynchronous and active-high. The clock port is clk and the reset port is rst.
REQ-003 clk  input  1  pipeline clock, all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request from EX stage; sampled only in IDLE.
REQ-006 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 a  input  32  rs1 operand (forwarded).
REQ-008 b  input  32  rs2 operand (forwarded).
REQ-009 flush  input  1  synchronous abort from hazard unit.
REQ-010 stall_req  output  1  combinational freeze request to IF/ID/EX segment registers.
REQ-011 busy  output  1  high while an operation iterates.
REQ-012 done  output  1  one-cycle pulse marking result valid.
REQ-013 result  output  32  registered result, driven into the EX/MEM AluOut path.

Function
REQ-014 FSM SHALL have states IDLE, CALC, DONE.
REQ-015 IDLE + start + !flush SHALL capture op, the magnitudes |a| and |b| (per signedness of op), the result sign, and a 6-bit counter of 0, then go to CALC.
REQ-016 Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned.
REQ-017 Multiply SHALL use radix-2 shift-add on a 64-bit unsigned accumulator, one bit per CALC cycle.
REQ-018 Divide SHALL use radix-2 restoring division, one quotient bit per CALC cycle.
REQ-019 CALC SHALL last exactly 32 cycles (counter 0..31), then go to DONE.
REQ-020 Entry to DONE SHALL apply 2's-complement sign correction and register result: MUL low 32 bits, MULH* high 32 bits, DIV*/REM* quotient or remainder.
REQ-021 Remainder sign SHALL follow the dividend; quotient sign SHALL be sign(a) XOR sign(b).
REQ-022 Fast path, IDLE to DONE in one cycle with no CALC: divide by zero SHALL give quotient 0xFFFFFFFF and remainder = a.
REQ-023 Fast path: signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM) SHALL give quotient 0x80000000 and remainder 0.
REQ-024 done SHALL be 1 only in DONE; DONE SHALL return to IDLE after one cycle.
REQ-025 Latency: start sampled at edge T gives done high in the cycle after edge T+33 (normal) or T+1 (fast path).
REQ-026 busy SHALL equal (state==CALC).
REQ-027 stall_req SHALL equal (state==IDLE & start & !flush) | (state==CALC), so the pipeline holds until the DONE cycle.
REQ-028 start in CALC or DONE SHALL be ignored.
REQ-029 start in the DONE cycle SHALL be accepted on the following IDLE cycle only.
REQ-030 flush in any state SHALL force IDLE on the next edge, suppress done, and leave result unchanged.
REQ-031 flush with start in IDLE SHALL not start an operation.
REQ-032 result SHALL hold its value until the next DONE entry.

Reset
REQ-033 rst high SHALL immediately force state IDLE, counter 0, result 0x00000000, done 0, busy 0, stall_req 0, including mid-CALC; the operation is discarded.
REQ-034 After rst deasserts, the first start SHALL behave per REQ-015.

Verification
REQ-035 MUL a=7, b=0xFFFFFFFD -> stall_req high 33 cycles, done after edge T+33, result 0xFFFFFFEB.
REQ-036 MULH a=b=0x80000000 -> result 0x40000000; MULHU same operands -> result 0x40000000; MULHSU a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFF.
REQ-037 DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD; REM same operands -> result 0xFFFFFFFF; DIVU 100/7 -> result 14; REMU 100/7 -> result 2.
REQ-038 DIVU a=5, b=0 -> done at T+1, result 0xFFFFFFFF; REM a=5, b=0 -> result 5; DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 via fast path.
REQ-039 start pulsed during CALC -> ignored, single done; flush at CALC cycle 10 -> IDLE next cycle, no done, result keeps prior value.
REQ-040 rst asserted at CALC cycle 20 -> outputs 0 asynchronously; after release, MUL 3*4 -> result 12.
